// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite to native register-bus bridge.
// Accepts one write (AW+W together) or one read (AR) at a time, issues a single bus access,
// then returns the B or R response before accepting the next transaction.
module rggen_axi4lite_bridge #(
   parameter int unsigned ID_WIDTH      = 0,
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned BUS_WIDTH     = 32
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst,
   input  logic                                       i_awvalid,
   output logic                                       o_awready,
   input  logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] i_awid,
   input  logic [ADDRESS_WIDTH-1:0]                   i_awaddr,
   input  logic                                       i_wvalid,
   output logic                                       o_wready,
   input  logic [BUS_WIDTH-1:0]                       i_wdata,
   input  logic [BUS_WIDTH/8-1:0]                     i_wstrb,
   output logic                                       o_bvalid,
   input  logic                                       i_bready,
   output logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] o_bid,
   output logic [1:0]                                 o_bresp,
   input  logic                                       i_arvalid,
   output logic                                       o_arready,
   input  logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] i_arid,
   input  logic [ADDRESS_WIDTH-1:0]                   i_araddr,
   output logic                                       o_rvalid,
   input  logic                                       i_rready,
   output logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] o_rid,
   output logic [1:0]                                 o_rresp,
   output logic [BUS_WIDTH-1:0]                       o_rdata,
   output logic                                       o_bus_valid,
   output logic                                       o_bus_write,
   output logic [ADDRESS_WIDTH-1:0]                   o_bus_address,
   output logic [BUS_WIDTH-1:0]                       o_bus_write_data,
   output logic [BUS_WIDTH/8-1:0]                     o_bus_strobe,
   input  logic                                       i_bus_ready,
   input  logic [1:0]                                 i_bus_status,
   input  logic [BUS_WIDTH-1:0]                       i_bus_read_data
);

   localparam int unsigned IdW   = (ID_WIDTH > 0) ? ID_WIDTH : 1;
   localparam int unsigned StrbW = BUS_WIDTH / 8;
   // Clears the byte-offset bits so the bus always sees a word-aligned address
   localparam logic [ADDRESS_WIDTH-1:0] AddrMask = ~ADDRESS_WIDTH'(StrbW - 1);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StWriteResp,
      StReadResp
   } state_e;

   state_e                   state_q;
   logic                     prio_read_q;   // 1: read wins the next conflict
   logic [IdW-1:0]           id_q;
   logic                     bus_valid_q;
   logic                     bus_write_q;
   logic [ADDRESS_WIDTH-1:0] bus_addr_q;
   logic [BUS_WIDTH-1:0]     bus_wdata_q;
   logic [StrbW-1:0]         bus_strb_q;
   logic                     bvalid_q;
   logic                     rvalid_q;
   logic [1:0]               status_q;
   logic [BUS_WIDTH-1:0]     rdata_q;

   logic write_req;
   logic write_grant;
   logic read_grant;
   logic accepting;

   // Arbitration: a lone requester always wins, a conflict goes to the type not served last
   always_comb begin
      write_req   = i_awvalid & i_wvalid;
      write_grant = write_req & (~i_arvalid | ~prio_read_q);
      read_grant  = i_arvalid & (~write_req | prio_read_q);
      accepting   = (state_q == StIdle) & ~i_rst;
   end

   // Ready is gated by reset so no handshake completes in a cycle the FSM discards
   assign o_awready = accepting & write_grant;
   assign o_wready  = accepting & write_grant;
   assign o_arready = accepting & read_grant;

   assign o_bid            = (ID_WIDTH > 0) ? id_q : '0;
   assign o_rid            = (ID_WIDTH > 0) ? id_q : '0;
   assign o_bvalid         = bvalid_q;
   assign o_rvalid         = rvalid_q;
   assign o_bresp          = status_q;
   assign o_rresp          = status_q;
   assign o_rdata          = rdata_q;
   assign o_bus_valid      = bus_valid_q;
   assign o_bus_write      = bus_write_q;
   assign o_bus_address    = bus_addr_q;
   assign o_bus_write_data = bus_wdata_q;
   assign o_bus_strobe     = bus_strb_q;

   // Transaction FSM with all outputs registered
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         prio_read_q <= 1'b0;
         id_q        <= '0;
         bus_valid_q <= 1'b0;
         bus_write_q <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_strb_q  <= '0;
         bvalid_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         status_q    <= '0;
         rdata_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (write_grant) begin
                  id_q        <= i_awid;
                  bus_addr_q  <= i_awaddr & AddrMask;
                  bus_wdata_q <= i_wdata;
                  bus_strb_q  <= i_wstrb;
                  bus_write_q <= 1'b1;
                  bus_valid_q <= 1'b1;
                  prio_read_q <= 1'b1;
                  state_q     <= StAccess;
               end else if (read_grant) begin
                  id_q        <= i_arid;
                  bus_addr_q  <= i_araddr & AddrMask;
                  bus_wdata_q <= '0;
                  bus_strb_q  <= '1;
                  bus_write_q <= 1'b0;
                  bus_valid_q <= 1'b1;
                  prio_read_q <= 1'b0;
                  state_q     <= StAccess;
               end
            end
            StAccess: begin
               if (i_bus_ready) begin
                  bus_valid_q <= 1'b0;
                  status_q    <= i_bus_status;
                  rdata_q     <= i_bus_read_data;
                  if (bus_write_q) begin
                     bvalid_q <= 1'b1;
                     state_q  <= StWriteResp;
                  end else begin
                     rvalid_q <= 1'b1;
                     state_q  <= StReadResp;
                  end
               end
            end
            StWriteResp: begin
               if (i_bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            StReadResp: begin
               if (i_rready) begin
                  rvalid_q <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Directed bench for rggen_axi4lite_bridge: inputs change 1 ns after the rising edge,
// registered outputs are sampled there, combinational readies 1 ns later.
module tb_rggen_axi4lite_bridge;

   logic        clk;
   logic        rst;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [3:0]  awid, arid, bid, rid;
   logic [7:0]  awaddr, araddr, bus_address;
   logic [31:0] wdata, rdata, bus_write_data, bus_read_data;
   logic [3:0]  wstrb, bus_strobe;
   logic [1:0]  bresp, rresp, bus_status;
   logic        bus_valid, bus_write, bus_ready;

   int n_cmp;
   int n_err;

   rggen_axi4lite_bridge #(
      .ID_WIDTH      (4),
      .ADDRESS_WIDTH (8),
      .BUS_WIDTH     (32)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_awvalid        (awvalid),
      .o_awready        (awready),
      .i_awid           (awid),
      .i_awaddr         (awaddr),
      .i_wvalid         (wvalid),
      .o_wready         (wready),
      .i_wdata          (wdata),
      .i_wstrb          (wstrb),
      .o_bvalid         (bvalid),
      .i_bready         (bready),
      .o_bid            (bid),
      .o_bresp          (bresp),
      .i_arvalid        (arvalid),
      .o_arready        (arready),
      .i_arid           (arid),
      .i_araddr         (araddr),
      .o_rvalid         (rvalid),
      .i_rready         (rready),
      .o_rid            (rid),
      .o_rresp          (rresp),
      .o_rdata          (rdata),
      .o_bus_valid      (bus_valid),
      .o_bus_write      (bus_write),
      .o_bus_address    (bus_address),
      .o_bus_write_data (bus_write_data),
      .o_bus_strobe     (bus_strobe),
      .i_bus_ready      (bus_ready),
      .i_bus_status     (bus_status),
      .i_bus_read_data  (bus_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [94:0] all_outs();
      return {awready, wready, arready, bvalid, bid, bresp, rvalid, rid, rresp, rdata,
              bus_valid, bus_write, bus_address, bus_write_data, bus_strobe};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      awvalid = 0; awid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
      arvalid = 0; arid = 0; araddr = 0; rready = 0;
      bus_ready = 0; bus_status = 0; bus_read_data = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
      #1;
      n_cmp++;
      if (all_outs() !== 95'd0) begin
         n_err++; $display("FAIL reset_outputs: got %h want 0", all_outs());
      end
   endtask

   task automatic test_write();
      awvalid = 1; wvalid = 1; awid = 4'h3; awaddr = 8'h13; wdata = 32'hA5A5_0F0F;
      wstrb = 4'b0101;
      #1;
      n_cmp++;
      if ({awready, wready, arready} !== 3'b110) begin
         n_err++; $display("FAIL write_accept: got %b want 110", {awready, wready, arready});
      end
      tick();
      awvalid = 0; wvalid = 0; awaddr = 8'hFF; wdata = 0; wstrb = 0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({bus_valid, bus_write, bus_address, bus_write_data, bus_strobe} !==
             {1'b1, 1'b1, 8'h10, 32'hA5A5_0F0F, 4'b0101}) begin
            n_err++;
            $display("FAIL write_bus cyc%0d: got v=%b w=%b a=%h d=%h s=%b want 1 1 10 a5a50f0f 0101",
                     i, bus_valid, bus_write, bus_address, bus_write_data, bus_strobe);
         end
         if (i == 1) begin
            bus_ready = 1; bus_status = 2'b00; bus_read_data = 32'h1234_5678;
         end
         tick();
      end
      bus_ready = 0;
      n_cmp++;
      if ({bvalid, bresp, bid, bus_valid, rvalid} !== {1'b1, 2'b00, 4'h3, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL write_resp: got bv=%b br=%b bid=%h busv=%b rv=%b want 1 00 3 0 0",
                  bvalid, bresp, bid, bus_valid, rvalid);
      end
      bready = 1;
      tick();
      bready = 0;
      n_cmp++;
      if (bvalid !== 1'b0) begin
         n_err++; $display("FAIL write_b_done: got bvalid=%b want 0", bvalid);
      end
   endtask

   task automatic test_read();
      arvalid = 1; arid = 4'h5; araddr = 8'h24;
      #1;
      n_cmp++;
      if ({awready, wready, arready} !== 3'b001) begin
         n_err++; $display("FAIL read_accept: got %b want 001", {awready, wready, arready});
      end
      tick();
      arvalid = 0; araddr = 0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({bus_valid, bus_write, bus_address, bus_write_data, bus_strobe, rvalid} !==
             {1'b1, 1'b0, 8'h24, 32'h0, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL read_bus cyc%0d: got v=%b w=%b a=%h d=%h s=%b rv=%b want 1 0 24 0 f 0",
                     i, bus_valid, bus_write, bus_address, bus_write_data, bus_strobe, rvalid);
         end
         if (i == 3) begin
            bus_ready = 1; bus_status = 2'b10; bus_read_data = 32'hDEAD_BEEF;
         end
         tick();
      end
      bus_ready = 0; bus_read_data = 0; bus_status = 0;
      n_cmp++;
      if ({rvalid, rdata, rresp, rid, bus_valid, bvalid} !==
          {1'b1, 32'hDEAD_BEEF, 2'b10, 4'h5, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL read_resp: got rv=%b d=%h r=%b id=%h busv=%b bv=%b want 1 deadbeef 10 5 0 0",
                  rvalid, rdata, rresp, rid, bus_valid, bvalid);
      end
      rready = 1;
      tick();
      rready = 0;
      n_cmp++;
      if (rvalid !== 1'b0) begin
         n_err++; $display("FAIL read_r_done: got rvalid=%b want 0", rvalid);
      end
   endtask

   // Both types request continuously after a reset: grants must alternate W, R, W, R
   task automatic test_arbitration();
      logic exp_w;
      logic [1:0] st;
      test_reset();
      awvalid = 1; wvalid = 1; awid = 4'h9; awaddr = 8'h0B; wdata = 32'h0BAD_F00D; wstrb = 4'hC;
      arvalid = 1; arid = 4'hA; araddr = 8'h31;
      for (int i = 0; i < 4; i++) begin
         exp_w = (i % 2 == 0);
         st    = 2'(i);
         #1;
         n_cmp++;
         if ({awready, wready, arready} !== {exp_w, exp_w, ~exp_w}) begin
            n_err++;
            $display("FAIL arb_grant #%0d: got %b want %b", i, {awready, wready, arready},
                     {exp_w, exp_w, ~exp_w});
         end
         tick();
         n_cmp++;
         if ({bus_valid, bus_write, bus_address, arready, awready} !==
             {1'b1, exp_w, (exp_w ? 8'h08 : 8'h30), 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL arb_access #%0d: got v=%b w=%b a=%h ar=%b aw=%b want 1 %b %h 0 0",
                     i, bus_valid, bus_write, bus_address, arready, awready, exp_w,
                     (exp_w ? 8'h08 : 8'h30));
         end
         bus_ready = 1; bus_status = st; bus_read_data = 32'h5500_0000 | 32'(i);
         tick();
         bus_ready = 0;
         n_cmp++;
         if ({bvalid, rvalid, bresp, rresp, arready} !== {exp_w, ~exp_w, st, st, 1'b0}) begin
            n_err++;
            $display("FAIL arb_resp #%0d: got bv=%b rv=%b br=%b rr=%b ar=%b want %b %b %b %b 0",
                     i, bvalid, rvalid, bresp, rresp, arready, exp_w, ~exp_w, st, st);
         end
         bready = 1; rready = 1;
         tick();
         bready = 0; rready = 0;
      end
      clear_inputs();
   endtask

   task automatic test_lone_aw();
      awvalid = 1; awid = 4'h7; awaddr = 8'h42;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++;
         if ({awready, wready, bus_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL lone_aw cyc%0d: got aw=%b w=%b busv=%b want 0 0 0",
                     i, awready, wready, bus_valid);
         end
         tick();
      end
      wvalid = 1; wdata = 32'hCAFE_0001; wstrb = 4'hF;
      #1;
      n_cmp++;
      if ({awready, wready} !== 2'b11) begin
         n_err++; $display("FAIL lone_aw_join: got %b want 11", {awready, wready});
      end
      tick();
      awvalid = 0; wvalid = 0;
      bus_ready = 1; bus_status = 2'b01;
      tick();
      bus_ready = 0;
      n_cmp++;
      if ({bvalid, bresp, bid} !== {1'b1, 2'b01, 4'h7}) begin
         n_err++;
         $display("FAIL lone_aw_resp: got bv=%b br=%b bid=%h want 1 01 7", bvalid, bresp, bid);
      end
      bready = 1;
      tick();
      bready = 0;
   endtask

   task automatic test_bready_hold();
      awvalid = 1; wvalid = 1; awid = 4'hE; awaddr = 8'h50; wdata = 32'h1; wstrb = 4'h1;
      tick();
      awvalid = 0; wvalid = 0;
      bus_ready = 1; bus_status = 2'b11;
      tick();
      bus_ready = 0; bus_status = 0;
      arvalid = 1; arid = 4'h2; araddr = 8'h60;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_cmp++;
         if ({bvalid, bid, bresp, arready, bus_valid} !== {1'b1, 4'hE, 2'b11, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL b_hold cyc%0d: got bv=%b bid=%h br=%b ar=%b busv=%b want 1 e 11 0 0",
                     i, bvalid, bid, bresp, arready, bus_valid);
         end
         tick();
      end
      bready = 1;
      tick();
      bready = 0;
      #1;
      n_cmp++;
      if ({bvalid, arready} !== 2'b01) begin
         n_err++; $display("FAIL b_hold_release: got bv=%b ar=%b want 0 1", bvalid, arready);
      end
      tick();
      arvalid = 0;
      bus_ready = 1; bus_read_data = 32'h0000_0060;
      tick();
      bus_ready = 0;
      n_cmp++;
      if ({rvalid, rid, rdata} !== {1'b1, 4'h2, 32'h0000_0060}) begin
         n_err++;
         $display("FAIL b_hold_read: got rv=%b rid=%h d=%h want 1 2 00000060", rvalid, rid, rdata);
      end
      rready = 1;
      tick();
      rready = 0;
   endtask

   task automatic test_reset_in_access();
      awvalid = 1; wvalid = 1; awid = 4'h6; awaddr = 8'h77; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      tick();
      clear_inputs();
      n_cmp++;
      if (bus_valid !== 1'b1) begin
         n_err++; $display("FAIL rst_access_pre: got busv=%b want 1", bus_valid);
      end
      rst = 1;
      tick();
      rst = 0;
      bus_ready = 1; bus_status = 2'b10; bus_read_data = 32'hFEED_FACE;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (all_outs() !== 95'd0) begin
            n_err++; $display("FAIL rst_access cyc%0d: got %h want 0", i, all_outs());
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1;
      clear_inputs();
      test_reset();
      test_write();
      test_read();
      test_arbitration();
      test_lone_aw();
      test_bready_hold();
      test_reset_in_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
